// File: rtl/seg7_pkg.sv
// Shared types and helpers for the 7-segment display arbiter.
// A display value is four packed BCD digits.
package seg7_pkg;
  localparam int DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    OPEN = 2'd2
  } state_t;

  function automatic logic bcd_valid(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int d = 0; d < DIGITS; d++)
      if (v[4*d +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set req bit scanning cyclically from
// start. With excl_cur the index just before start (the current owner) is skipped.
module rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      start,
  input  logic               excl_cur,
  output logic               found,
  output logic [IW-1:0]      idx
);
  logic [IW-1:0] pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = IW'((int'(start) + k) % NUM_REQ);
      // The last slot of the scan is the current owner itself.
      if (!found && !(excl_cur && k == NUM_REQ - 1) && req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end
endmodule

// File: rtl/seg7_display_arbiter.sv
// Round-robin owner of the shared 4-digit 7-segment display with a minimum
// dwell per grant; the owner's value is registered onto bits every cycle.
module seg7_display_arbiter
  import seg7_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  value,
  output logic [NUM_REQ-1:0]     grant,
  output logic [15:0]            bits,
  output logic                   bcd_err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(DWELL_CYCLES) + 1;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [IW-1:0]   owner, owner_nx;
  logic [IW-1:0]   ptr;
  logic            found;
  logic [IW-1:0]   pick;
  logic [15:0]     bits_nx;
  logic [NUM_REQ-1:0] grant_nx;

  // ptr is always (last owner + 1), so one picker serves both IDLE and OPEN.
  rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req      (req),
    .start    (ptr),
    .excl_cur (state == OPEN),
    .found    (found),
    .idx      (pick)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    owner_nx = owner;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx = HOLD;
          owner_nx = pick;
          cnt_nx   = '0;
        end
      end
      HOLD: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == CW'(DWELL_CYCLES - 1)) state_nx = OPEN;
      end
      OPEN: begin
        if (found) begin
          state_nx = HOLD;
          owner_nx = pick;
          cnt_nx   = '0;
        end else if (!req[owner]) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bits_nx  = '0;
    grant_nx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_nx == IW'(i)) begin
        bits_nx     = value[16*i +: 16];
        grant_nx[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      owner   <= '0;
      ptr     <= '0;
      grant   <= '0;
      bits    <= '0;
      bcd_err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      owner <= owner_nx;
      if (state_nx != IDLE) begin
        grant   <= grant_nx;
        bits    <= bits_nx;
        bcd_err <= !bcd_valid(bits_nx);
        ptr     <= (owner_nx == IW'(NUM_REQ - 1)) ? '0 : owner_nx + 1'b1;
      end else begin
        // Idle keeps the last displayed value and its error flag.
        grant <= '0;
      end
    end
  end
endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Directed bench for seg7_display_arbiter with a cycle model of owner/age
// compared every cycle, plus literal expectations at key points.
module tb_seg7_display_arbiter;
  localparam int N  = 3;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [16*N-1:0] value;
  logic [N-1:0]  grant;
  logic [15:0]   bits;
  logic          bcd_err;

  int vectors = 0;
  int miscompares = 0;

  seg7_display_arbiter #(.NUM_REQ(N), .DWELL_CYCLES(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .value(value),
    .grant(grant), .bits(bits), .bcd_err(bcd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: owner index (-1 = nobody), cycles owned so far, last owner.
  int   m_own, m_age, m_last;
  logic [15:0] m_bits;
  logic m_err;
  bit   started = 0;

  function automatic int rr(input logic [N-1:0] r, input int from, input int skip);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (from + k) % N;
      if (i != skip && r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic bad_bcd(input logic [15:0] v);
    for (int d = 0; d < 4; d++)
      if (((v >> (4*d)) & 16'hF) > 9) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    int p;
    if (rst) begin
      m_own = -1; m_age = 0; m_last = N - 1; m_bits = 16'h0000; m_err = 1'b0;
    end else if (m_own < 0) begin
      p = rr(req, m_last + 1, -1);
      if (p >= 0) begin m_own = p; m_last = p; m_age = 0; end
    end else if (m_age < DW) begin
      m_age++;
    end else begin
      p = rr(req, m_own + 1, m_own);
      if (p >= 0) begin m_own = p; m_last = p; m_age = 0; end
      else if (!req[m_own]) m_own = -1;
    end
    if (!rst && m_own >= 0) begin
      m_bits = value[m_own*16 +: 16];
      m_err  = bad_bcd(m_bits);
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_grant", 32'(grant), (m_own < 0) ? 32'd0 : 32'(1 << m_own));
      chk("model_bits", 32'(bits), 32'(m_bits));
      chk("model_bcd_err", 32'(bcd_err), 32'(m_err));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rst_pulse();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  logic [2:0] rr_seq [4];

  initial begin
    rst = 1'b1; req = '0; value = '0;
    tick(); tick();
    rst = 1'b0;
    // Reset then idle
    for (int i = 0; i < 20; i++) begin
      chk("idle_grant", 32'(grant), 32'd0);
      chk("idle_bits", 32'(bits), 32'h0000);
      chk("idle_err", 32'(bcd_err), 32'd0);
      tick();
    end

    // Single requester, live value tracking, early req drop
    value[16 +: 16] = 16'h1234; req = 3'b010;
    tick();
    chk("single_grant", 32'(grant), 32'b010);
    chk("single_bits", 32'(bits), 32'h1234);
    value[16 +: 16] = 16'h1235;
    tick();
    chk("single_track", 32'(bits), 32'h1235);
    req = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("single_locked", 32'(grant), 32'b010);
    end
    tick();
    chk("single_idle_grant", 32'(grant), 32'd0);
    chk("single_idle_bits", 32'(bits), 32'h1235);
    // Idle search resumes after last owner (1) -> index 2 first
    req = 3'b111;
    tick();
    chk("idle_rr_start", 32'(grant), 32'b100);

    // Round-robin rotation from a fresh reset
    req = '0; rst_pulse();
    value = {16'h0003, 16'h0002, 16'h0001}; req = 3'b111;
    rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100; rr_seq[3] = 3'b001;
    tick();
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 5; c++) begin
        chk("rr_grant", 32'(grant), 32'(rr_seq[s]));
        chk("rr_bits", 32'(bits), (s == 1) ? 32'h2 : (s == 2) ? 32'h3 : 32'h1);
        tick();
      end
    end

    // Preemption blocked during HOLD
    req = '0; rst_pulse();
    value[0 +: 16] = 16'h1111; req = 3'b001;
    tick();
    chk("pre_grant0", 32'(grant), 32'b001);
    req = 3'b101;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pre_locked", 32'(grant), 32'b001);
    end
    tick();
    chk("pre_switch", 32'(grant), 32'b100);
    // Owner drops while another raises in OPEN: direct handover
    for (int i = 0; i < 4; i++) tick();
    req = 3'b010;
    tick();
    chk("handover", 32'(grant), 32'b010);
    req = '0;
    for (int i = 0; i < 6; i++) tick();
    chk("handover_idle", 32'(grant), 32'd0);

    // BCD error flag
    rst_pulse();
    value[0 +: 16] = 16'h12A4; req = 3'b001;
    tick();
    chk("bcd_bits_bad", 32'(bits), 32'h12A4);
    chk("bcd_err_set", 32'(bcd_err), 32'd1);
    value[0 +: 16] = 16'h1294;
    tick();
    chk("bcd_bits_ok", 32'(bits), 32'h1294);
    chk("bcd_err_clr", 32'(bcd_err), 32'd0);
    req = '0;
    for (int i = 0; i < 6; i++) tick();

    // Mid-grant reset
    rst_pulse();
    value[16 +: 16] = 16'h4321; req = 3'b010;
    tick();
    chk("mid_grant", 32'(grant), 32'b010);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_bits", 32'(bits), 32'h0000);
    chk("mid_rst_err", 32'(bcd_err), 32'd0);
    rst = 1'b0; req = 3'b111;
    tick();
    chk("post_rst_grant", 32'(grant), 32'b001);
    chk("post_rst_bits", 32'(bits), 32'h1294);
    req = '0;
    for (int i = 0; i < 8; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
